// File: rtl/gf_mul_prod_157_if.sv
// Operand/product handshake bundle for the GF(157) shift-and-add multiplier.
// The slave side is the multiplier; the master side feeds operands and takes products.
interface gf_mul_prod_157_if #(
  parameter int W  = 8,
  parameter int PW = 15
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  din_a;
  logic [W-1:0]  din_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] dout_p;
  logic          err;

  modport master (
    output in_valid, din_a, din_b, out_ready,
    input  in_ready, out_valid, dout_p, err
  );

  modport slave (
    input  in_valid, din_a, din_b, out_ready,
    output in_ready, out_valid, dout_p, err
  );
endinterface

// File: rtl/gf_mul_prod_157.sv
// Sequential shift-and-add multiplier producing the 15-bit raw product for the p=157 Barrett reducer.
// Optional operand range flag: define GF_MUL_OPERAND_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// BUSY  | W fixed shift-and-add steps, one per cycle
// DONE  | product presented with out_valid=1 until out_ready
module gf_mul_prod_157 #(
  parameter int P  = 157,
  parameter int W  = 8,
  parameter int PW = 15
) (
  input  logic            clk,
  input  logic            rst,
  gf_mul_prod_157_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  // The largest in-range product must fit the reducer input.
  if ((P - 1) * (P - 1) >= (1 << PW)) begin : g_pw_check
    $error("PW too narrow for (P-1)^2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  a_sh;
  logic [W-1:0]    b_sh;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  acc_next;
  logic            load;
  logic            out_valid_q;
  logic [PW-1:0]   dout_p_q;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign load          = bus.in_valid && bus.in_ready;
  assign acc_next      = b_sh[0] ? (acc + a_sh) : acc;
  assign bus.out_valid = out_valid_q;
  assign bus.dout_p    = dout_p_q;

`ifdef GF_MUL_OPERAND_CHECK_EN
  logic bad_q;
  logic err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      dout_p_q    <= '0;
`ifdef GF_MUL_OPERAND_CHECK_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          acc   <= acc_next;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh >> 1;
          count <= count + 1'b1;
          if (count == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
`ifdef GF_MUL_OPERAND_CHECK_EN
            dout_p_q    <= bad_q ? '0 : acc_next[PW-1:0];
            err_q       <= bad_q;
`else
            dout_p_q    <= acc_next[PW-1:0];
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
`ifdef GF_MUL_OPERAND_CHECK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // Acceptance from IDLE or from DONE overrides the state chosen above,
      // which gives the bubble-free DONE -> BUSY handoff.
      if (load) begin
        state <= BUSY;
        acc   <= '0;
        a_sh  <= {{W{1'b0}}, bus.din_a};
        b_sh  <= bus.din_b;
        count <= '0;
`ifdef GF_MUL_OPERAND_CHECK_EN
        bad_q <= (bus.din_a >= W'(P)) || (bus.din_b >= W'(P));
`endif
      end
    end
  end

endmodule

// File: tb/tb_gf_mul_prod_157.sv
// Scoreboard bench for gf_mul_prod_157: directed vectors push expected products,
// a monitor pops and compares on every accepted output.
module tb_gf_mul_prod_157;

  localparam int W  = 8;
  localparam int PW = 15;
  localparam int P  = 157;

  typedef struct {
    int   p;
    logic e;
    int   m;
  } exp_t;

  logic clk;
  logic rst;
  logic stall_en;
  logic ready_drv;
  logic rnd_ready;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   acc_cyc;
  exp_t exp_q[$];

  gf_mul_prod_157_if #(.W(W), .PW(PW)) intf ();

  gf_mul_prod_157 #(.P(P), .W(W), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  assign intf.out_ready = stall_en ? rnd_ready : ready_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Runs forever; samples 1 ns before each rising edge.
  task automatic monitor();
    logic     prev_stall;
    int       prev_p;
    logic     prev_e;
    exp_t     x;
    prev_stall = 1'b0;
    prev_p     = 0;
    prev_e     = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_en) rnd_ready = 1'($urandom_range(0, 1));
      #4;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("held_valid", int'(intf.out_valid), 1);
          check("held_dout_p", int'(intf.dout_p), prev_p);
          check("held_err", int'(intf.err), int'(prev_e));
        end
        if (intf.out_valid && intf.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            x = exp_q.pop_front();
            check("dout_p", int'(intf.dout_p), x.p);
            check("err", int'(intf.err), int'(x.e));
            if (!x.e) check("reduced_mod157", int'(intf.dout_p) % P, x.m);
          end
        end
        prev_stall = intf.out_valid && !intf.out_ready;
        prev_p     = int'(intf.dout_p);
        prev_e     = intf.err;
      end
    end
  endtask

  // Presents a pair and pushes the expected result just before the accepting edge.
  task automatic send(input int a, input int b, input int ep, input logic ee);
    exp_t x;
    bit   ok;
    ok = 0;
    @(negedge clk);
    intf.in_valid = 1'b1;
    intf.din_a    = W'(a);
    intf.din_b    = W'(b);
    for (int i = 0; i < 60; i++) begin
      #4;
      if (intf.in_ready) begin
        x.p = ep;
        x.e = ee;
        x.m = ((a % P) * (b % P)) % P;
        exp_q.push_back(x);
        acc_cyc = cyc;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !intf.out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int first_cyc;
    int vals[12];
    bit seen;
    vals = '{0, 1, 2, 3, 12, 13, 50, 77, 99, 128, 155, 156};
    n_cmp = 0;
    n_bad = 0;
    stall_en = 1'b0;
    ready_drv = 1'b1;
    rnd_ready = 1'b0;
    acc_cyc = 0;
    intf.in_valid = 1'b0;
    intf.din_a = '0;
    intf.din_b = '0;
    rst = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(intf.out_valid), 0);
    check("rst_dout_p", int'(intf.dout_p), 0);
    check("rst_err", int'(intf.err), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(intf.in_ready), 1);

    // 156*156, exact 8-cycle latency
    send(156, 156, 24336, 1'b0);
    intf.in_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk);
      #1;
      if (j == 7) check("latency_before", int'(intf.out_valid), 0);
      if (j == 8) check("latency_at_w", int'(intf.out_valid), 1);
    end
    drain(20);

    // back-to-back: second accept lands in the DONE cycle of the first
    send(0, 77, 0, 1'b0);
    first_cyc = acc_cyc;
    send(1, 156, 156, 1'b0);
    check("b2b_accept_gap", acc_cyc - first_cyc, W + 1);
    intf.in_valid = 1'b0;
    drain(30);

    // output stall with a pending pair that must be ignored
    ready_drv = 1'b0;
    send(100, 3, 300, 1'b0);
    intf.din_a = 8'd7;
    intf.din_b = 8'd7;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (intf.out_valid) begin
        seen = 1;
        break;
      end
    end
    check("stall_valid_seen", int'(seen), 1);
    for (int k = 0; k < 5; k++) begin
      check("stall_dout_p", int'(intf.dout_p), 300);
      check("stall_in_ready", int'(intf.in_ready), 0);
      @(posedge clk);
      #1;
    end
    intf.in_valid = 1'b0;
    ready_drv = 1'b1;
    drain(20);

    // reset in the middle of BUSY aborts the pair
    send(50, 60, 3000, 1'b0);
    intf.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_out_valid", int'(intf.out_valid), 0);
    check("abort_in_ready", int'(intf.in_ready), 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (intf.out_valid) seen = 1;
    end
    check("abort_no_output", int'(seen), 0);
    send(2, 3, 6, 1'b0);
    intf.in_valid = 1'b0;
    drain(20);

    // out-of-range operand
`ifdef GF_MUL_OPERAND_CHECK_EN
    send(157, 2, 0, 1'b1);
`else
    send(157, 2, 314, 1'b0);
`endif
    intf.in_valid = 1'b0;
    drain(20);

    // sweep with random output stalls
    stall_en = 1'b1;
    foreach (vals[i]) begin
      foreach (vals[j]) begin
        send(vals[i], vals[j], vals[i] * vals[j], 1'b0);
      end
    end
    intf.in_valid = 1'b0;
    drain(200);
    stall_en = 1'b0;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf_mul_prod_157.md
Name: gf_mul_prod_157

Overview:
- Sequential shift-and-add multiplier for two GF(157) residues.
- Produces the 15-bit raw product consumed directly by the p=157 Barrett reducer (its 15-bit din_a input).
- Sits immediately upstream of the reducer in the modular-multiply datapath.
- Valid/ready handshake on input and output; one operation in flight at a time.

Parameters:
- P, 157, field prime; used only by the operand check.
- W, 8, operand width in bits; also the number of BUSY cycles.
- PW, 15, product output width; must equal the reducer input width.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- din_a  input  W  multiplicand
- din_b  input  W  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- dout_p  output  PW  product a*b
- err  output  1  operand out of range; meaningful only while out_valid=1

Behaviour:
- Reset (asynchronous, active-high, wins over everything):
  - State = IDLE; acc, a_sh, b_sh and count cleared.
  - out_valid=0, dout_p=0, err=0, in_ready=1 once rst deasserts.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a_sh=din_a zero-extended to 2W bits, b_sh=din_b, acc=0, count=0; go to BUSY.
- BUSY, one step per cycle:
  - If b_sh[0], acc += a_sh.
  - Then a_sh <<= 1, b_sh >>= 1, count++.
  - After the W-th step (count==W-1), go to DONE.
  - No early termination: latency is fixed regardless of operand values.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; dout_p=acc[PW-1:0], registered.
  - dout_p and err are held stable while out_valid && !out_ready.
  - On out_ready, the product is consumed.
  - If in_valid is also asserted in that same cycle, load the new operands and go directly to BUSY (no IDLE bubble); otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only; no path from in_valid.
- Latency:
  - Accept edge t gives out_valid=1 after edge t+W (W cycles).
  - Back-to-back throughput is one result per W+1 cycles when out_ready is held high.
- Width:
  - Accumulator is 2W bits; the top 2W-PW bits are dropped at the output.
  - For in-range operands the maximum product is 156*156 = 24336 < 2^15, so no loss.
- in_valid while BUSY or DONE (and not accepted) is ignored; the operands are not sampled.
- rst asserted mid-BUSY or mid-DONE aborts the operation. No output is produced for the aborted pair.

Optional Feature:
- Macro: GF_MUL_OPERAND_CHECK_EN
- Defined:
  - At acceptance, compare din_a>=P or din_b>=P and latch the result.
  - Flagged operation: still takes W cycles; in DONE, err=1 and dout_p is forced to 0.
  - err clears when the result is consumed or on reset.
- Not defined:
  - err is tied to 0 and no comparators are synthesized.
  - Out-of-range operands are multiplied as-is and truncated to PW bits; the result is not a valid reducer input.

Test Plan:
- a=156, b=156, out_ready=1 -> out_valid exactly 8 cycles after accept; dout_p=24336 (0x5F10); err=0.
- a=0,b=77 then a=1,b=156, issued back-to-back with out_ready=1 -> results 0 then 156. Second operand pair accepted in the DONE cycle of the first, with no IDLE cycle in between.
- a=100, b=3; out_ready held 0 for 5 cycles after out_valid -> dout_p=300 held stable, in_ready=0, a pending in_valid ignored; result consumed on the first out_ready=1 cycle.
- Accept a=50, b=60; assert rst at BUSY step 4 -> out_valid stays 0, in_ready=1 after release; next pair a=2, b=3 yields dout_p=6.
- With GF_MUL_OPERAND_CHECK_EN: a=157, b=2 -> out_valid after 8 cycles, err=1, dout_p=0. Without the macro: same stimulus gives err=0, dout_p=314.
- Sweep a,b over 0..156 with random out_ready stalls -> every dout_p equals a*b. Feed each result into the p=157 reducer and check its output equals (a*b) mod 157.
